// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the LC-3b fetch sequencer: I-cache request/response
// channel plus the instruction-register load channel toward decode.
interface fetch_sequencer_if;
    // Handshakes: imem_read is held high with imem_address stable until the
    // cycle imem_resp=1, which is the single cycle imem_rdata is valid.
    // ir_load is a one-cycle strobe raised only while ir_ready=1; ir_data and
    // ir_pc are meaningful only in that cycle.
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        ir_ready;
    logic        ir_load;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_resp,
        input  imem_rdata,
        input  ir_ready,
        output ir_load,
        output ir_data,
        output ir_pc
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_resp,
        output imem_rdata,
        output ir_ready,
        input  ir_load,
        input  ir_data,
        input  ir_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// LC-3b instruction fetch sequencer: issues I-cache reads at the fetch PC,
// hands each word to IR with its PC+2, and handles redirects and timeouts.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              redirect,
    input  logic [15:0]       redirect_pc,
    fetch_sequencer_if.master bus,
    output logic [15:0]       insn_count,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [15:0] RESET_ADDR    = RESET_PC & 16'hFFFE;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] ir_data_q, ir_data_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic [15:0] count_q, count_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;

    logic [15:0] pc_plus2;
    logic [15:0] redir_addr;
    logic [1:0]  after_done;
    logic        load;
    logic [15:0] out_data;
    logic [15:0] out_pc;
    logic        waiting;
    logic        entering;

    assign pc_plus2   = pc_q + 16'd2;
    assign redir_addr = redirect_pc & 16'hFFFE;
    assign after_done = enable ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        buf_d     = buf_q;
        ir_data_d = ir_data_q;
        ir_pc_d   = ir_pc_q;
        load      = 1'b0;
        out_data  = ir_data_q;
        out_pc    = ir_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (redirect) pc_d = redir_addr;
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_resp) begin
                    if (redirect) begin
                        pc_d    = redir_addr;
                        state_d = after_done;
                    end else if (bus.ir_ready) begin
                        // Bypass: IR takes the word straight off the response.
                        load     = 1'b1;
                        out_data = bus.imem_rdata;
                        out_pc   = pc_plus2;
                        pc_d     = pc_plus2;
                        state_d  = after_done;
                    end else begin
                        buf_d   = bus.imem_rdata;
                        pc_d    = pc_plus2;
                        state_d = ST_HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding read cannot be withdrawn; park the target.
                    target_d = redir_addr;
                    state_d  = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (bus.imem_resp) begin
                    pc_d    = redirect ? redir_addr : target_q;
                    state_d = after_done;
                end else if (redirect) begin
                    target_d = redir_addr;
                end
            end
            ST_HOLD: begin
                // pc_q already points past the buffered word.
                out_data = buf_q;
                out_pc   = pc_q;
                if (redirect) begin
                    pc_d    = redir_addr;
                    state_d = after_done;
                end else if (bus.ir_ready) begin
                    load    = 1'b1;
                    state_d = after_done;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            ir_data_d = out_data;
            ir_pc_d   = out_pc;
        end
        count_d = count_q + {15'd0, load};

        waiting  = ((state_q == ST_FETCH) || (state_q == ST_DISCARD)) && !bus.imem_resp;
        entering = ((state_d == ST_FETCH) || (state_d == ST_DISCARD)) &&
                   ((state_d != state_q) || bus.imem_resp);
        if (entering) begin
            wait_d = 16'd0;
        end else if (waiting && (wait_q != TIMEOUT_LIMIT)) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end
        err_d = err_q | (waiting && !entering && (wait_d == TIMEOUT_LIMIT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_ADDR;
            target_q  <= RESET_ADDR;
            buf_q     <= 16'd0;
            ir_data_q <= 16'd0;
            ir_pc_q   <= 16'd0;
            count_q   <= 16'd0;
            wait_q    <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            buf_q     <= buf_d;
            ir_data_q <= ir_data_d;
            ir_pc_q   <= ir_pc_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

    assign bus.imem_read    = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign bus.imem_address = pc_q;
    assign bus.ir_load      = load;
    assign bus.ir_data      = out_data;
    assign bus.ir_pc        = out_pc;
    assign insn_count       = count_q;
    assign timeout_err      = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level fetch model checked every cycle,
// plus directed scenarios with hand-computed addresses, words and counts.
module tb_fetch_sequencer;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'd0;
    logic [15:0] insn_count;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .insn_count(insn_count),
        .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers after mem_lat wait cycles (0 = same cycle).
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hC3A5);
    endfunction

    int   mem_lat = 2;
    logic mem_on = 1'b1;
    int   mem_cnt = 0;
    int   resp_count = 0;

    assign bus.imem_resp  = mem_on && bus.imem_read && (mem_cnt == mem_lat);
    assign bus.imem_rdata = mem_word(bus.imem_address);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_cnt <= 0;
        end else if (bus.imem_read && !bus.imem_resp) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
        if (reset_n && bus.imem_resp) resp_count <= resp_count + 1;
    end

    // Reference model: outstanding request, words awaiting IR, next fetch PC.
    logic        m_read = 1'b0;
    logic [15:0] m_addr = 16'd0;
    logic [15:0] m_next_pc = 16'd0;
    logic        m_stale = 1'b0;
    int          m_wait = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_count = 16'd0;
    logic [31:0] exp_q[$];

    logic        prev_read = 1'b0;
    logic        prev_resp = 1'b0;
    logic [15:0] req_log[$];
    logic [15:0] ld_pc_log[$];
    logic [15:0] ld_data_log[$];

    always @(negedge clk) begin
        logic        resp;
        logic        exp_load;
        logic        cont;
        logic        nread;
        logic [31:0] item;
        if (!reset_n) begin
            m_read    = 1'b0;
            m_addr    = 16'd0;
            m_next_pc = 16'h0000;
            m_stale   = 1'b0;
            m_wait    = 0;
            m_err     = 1'b0;
            m_count   = 16'd0;
            exp_q.delete();
            prev_read = 1'b0;
            prev_resp = 1'b0;
        end else begin
            check1("imem_read", bus.imem_read, m_read);
            if (m_read) check16("imem_address", bus.imem_address, m_addr);
            check16("insn_count", insn_count, m_count);
            check1("timeout_err", timeout_err, m_err);
            if (bus.imem_read && !(prev_read && !prev_resp)) req_log.push_back(bus.imem_address);

            resp = m_read && bus.imem_resp;
            if (resp && !m_stale && !redirect) exp_q.push_back({mem_word(m_addr), m_addr + 16'd2});
            exp_load = (exp_q.size() != 0) && bus.ir_ready && !redirect;
            check1("ir_load", bus.ir_load, exp_load);
            if (exp_load) begin
                item = exp_q.pop_front();
                check16("ir_data", bus.ir_data, item[31:16]);
                check16("ir_pc", bus.ir_pc, item[15:0]);
                m_count = m_count + 16'd1;
            end
            if (bus.ir_load) begin
                ld_data_log.push_back(bus.ir_data);
                ld_pc_log.push_back(bus.ir_pc);
            end
            if (redirect) exp_q.delete();

            cont = m_read && !resp;
            if (cont) begin
                if (redirect && !m_stale) m_wait = 0;
                else if (m_wait < TMO) m_wait = m_wait + 1;
                if (m_wait == TMO) m_err = 1'b1;
            end
            if (redirect) begin
                m_next_pc = redirect_pc & 16'hFFFE;
                if (cont) m_stale = 1'b1;
            end else if (resp && !m_stale) begin
                m_next_pc = m_addr + 16'd2;
            end

            if (cont) nread = 1'b1;
            else if (exp_q.size() != 0) nread = 1'b0;
            else nread = enable;
            if (nread && !cont) begin
                m_addr  = m_next_pc;
                m_stale = 1'b0;
                m_wait  = 0;
            end
            m_read = nread;
            prev_read = bus.imem_read;
            prev_resp = bus.imem_resp;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [15:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        step();
        redirect    = 1'b0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        ld_pc_log.delete();
        ld_data_log.delete();
    endtask

    task automatic wait_loads(input int n);
        int k = 0;
        while (ld_pc_log.size() < n && k < 500) begin
            step();
            k++;
        end
        if (k >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_loads: got %0d loads, expected %0d", ld_pc_log.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((bus.imem_read || dbg_state != 2'd0) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy, imem_read=%b", bus.imem_read);
        end
    endtask

    task automatic wait_resp();
        int r0 = resp_count;
        int k = 0;
        while (resp_count == r0 && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_resp: no response, count %0d", resp_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_imem_read"}, bus.imem_read, 1'b0);
        check16({tag, "_imem_address"}, bus.imem_address, 16'h0000);
        check1({tag, "_ir_load"}, bus.ir_load, 1'b0);
        check16({tag, "_ir_data"}, bus.ir_data, 16'h0000);
        check16({tag, "_ir_pc"}, bus.ir_pc, 16'h0000);
        check16({tag, "_insn_count"}, insn_count, 16'h0000);
        check1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.ir_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        enable       = 1'b1;
        bus.ir_ready = 1'b1;
        clear_logs();

        // Back-to-back fetches from RESET_PC with 2 wait cycles.
        wait_loads(3);
        check16("count_after_3", insn_count, 16'd3);
        enable = 1'b0;
        wait_idle();
        check16("seq_nreq", 16'(req_log.size() >= 3), 16'd1);
        check16("seq_req0", req_log[0], 16'h0000);
        check16("seq_req1", req_log[1], 16'h0002);
        check16("seq_req2", req_log[2], 16'h0004);
        check16("seq_pc0", ld_pc_log[0], 16'h0002);
        check16("seq_pc1", ld_pc_log[1], 16'h0004);
        check16("seq_data0", ld_data_log[0], 16'hC3A5);

        // Decode stalled when the word for 0x0010 arrives.
        clear_logs();
        bus.ir_ready = 1'b0;
        pulse_redirect(16'h0010);
        enable = 1'b1;
        wait_resp();
        for (int i = 0; i < 4; i++) begin
            check1("hold_read", bus.imem_read, 1'b0);
            check1("hold_load", bus.ir_load, 1'b0);
            step();
        end
        bus.ir_ready = 1'b1;
        #1;
        check1("hold_release_load", bus.ir_load, 1'b1);
        check16("hold_release_data", bus.ir_data, 16'h1234);
        check16("hold_release_pc", bus.ir_pc, 16'h0012);
        step();
        enable = 1'b0;
        wait_idle();
        check16("hold_req0", req_log[0], 16'h0010);
        check16("hold_req1", req_log[1], 16'h0012);

        // Redirect while a fetch is waiting: the stale word is dropped.
        clear_logs();
        mem_lat = 4;
        pulse_redirect(16'h0020);
        enable = 1'b1;
        step();
        step();
        pulse_redirect(16'h0101);
        k = resp_count;
        for (int i = 0; i < 50 && resp_count == k; i++) begin
            check16("discard_addr", bus.imem_address, 16'h0020);
            step();
        end
        wait_loads(1);
        enable = 1'b0;
        wait_idle();
        check16("discard_req0", req_log[0], 16'h0020);
        check16("discard_req1", req_log[1], 16'h0100);
        check16("discard_pc0", ld_pc_log[0], 16'h0102);
        check16("discard_data0", ld_data_log[0], 16'hC2A5);

        // Redirect in the same cycle as a response with decode ready.
        clear_logs();
        mem_lat = 3;
        pulse_redirect(16'h0200);
        enable = 1'b1;
        k = 0;
        while (!bus.imem_resp && k < 50) begin
            step();
            k++;
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        #1;
        check1("redir_resp_load", bus.ir_load, 1'b0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_loads(1);
        enable = 1'b0;
        wait_idle();
        check16("redir_req0", req_log[0], 16'h0200);
        check16("redir_req1", req_log[1], 16'h0300);
        check16("redir_pc0", ld_pc_log[0], 16'h0302);

        // PC wrap at the top of memory; redirect bit 0 is ignored.
        clear_logs();
        mem_lat = 1;
        pulse_redirect(16'hFFFF);
        enable = 1'b1;
        wait_loads(2);
        enable = 1'b0;
        wait_idle();
        check16("wrap_req0", req_log[0], 16'hFFFE);
        check16("wrap_pc0", ld_pc_log[0], 16'h0000);
        check16("wrap_req1", req_log[1], 16'h0000);
        check16("wrap_pc1", ld_pc_log[1], 16'h0002);

        // Memory never answers: timeout after TMO wait cycles, then async reset.
        mem_on = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!bus.imem_read && k < 20) begin
            step();
            k++;
        end
        repeat (TMO - 1) step();
        check1("tmo_before", timeout_err, 1'b0);
        step();
        check1("tmo_set", timeout_err, 1'b1);
        check1("tmo_read_held", bus.imem_read, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        enable = 1'b0;
        mem_on = 1'b1;

        // Zero-wait memory, one load per cycle: insn_count wraps after 65536.
        repeat (3) @(posedge clk);
        #1;
        mem_lat      = 0;
        bus.ir_ready = 1'b1;
        enable       = 1'b1;
        reset_n      = 1'b1;
        clear_logs();
        repeat (65536) @(posedge clk);
        #1;
        check16("count_ffff", insn_count, 16'hFFFF);
        @(posedge clk);
        #1;
        check16("count_wrap", insn_count, 16'h0000);
        enable = 1'b0;
        wait_idle();
        clear_logs();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
